regfile_wb_sched: RTL and testbench

- Write-back scheduler and hazard scoreboard in front of the 32-entry register file (ports RegWrite, write_reg, write_data).
- Shares the register file's single write port between three producers: ALU (req 0), load unit (req 1) and CSR unit (req 2), using round-robin arbitration with a valid/ready handshake.
- Tracks which registers have a write outstanding and stalls the issue stage on RAW and WAW hazards.
- Sits between the execute/memory units and the register file for the multi-cycle core variant.

---
 rtl/regfile_wb_sched.sv | 113 +++++++++++
 tb/tb_regfile_wb_sched.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_sched.sv
// rtl/regfile_wb_sched.sv - round-robin write-back arbiter and RAW/WAW scoreboard for the register file
module regfile_wb_sched #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           wb_valid,
  input  logic [3*IDX_W-1:0]   wb_rd,
  input  logic [3*XLEN-1:0]    wb_data,
  output logic [2:0]           wb_ready,
  input  logic                 issue_valid,
  input  logic [IDX_W-1:0]     issue_rd,
  input  logic [IDX_W-1:0]     rs1,
  input  logic [IDX_W-1:0]     rs2,
  output logic                 hazard_stall,
  output logic                 RegWrite,
  output logic [IDX_W-1:0]     write_reg,
  output logic [XLEN-1:0]      write_data
);

  logic [1:0]       ptr_q, ptr_d;
  logic [NREGS-1:0] pending_q, pending_d;
  logic             regwrite_q, regwrite_d;
  logic [IDX_W-1:0] write_reg_q, write_reg_d;
  logic [XLEN-1:0]  write_data_q, write_data_d;

  logic [2:0]       rot_valid, rot_grant, grant;
  logic [IDX_W-1:0] sel_rd;
  logic [XLEN-1:0]  sel_data;
  logic             xfer;
  logic             issue_fire;

  // Rotate so bit 0 is the requester the pointer favours, pick the first, rotate back.
  always_comb begin
    case (ptr_q)
      2'd1:    rot_valid = {wb_valid[0], wb_valid[2:1]};
      2'd2:    rot_valid = {wb_valid[1:0], wb_valid[2]};
      default: rot_valid = wb_valid;
    endcase
    if (rot_valid[0])      rot_grant = 3'b001;
    else if (rot_valid[1]) rot_grant = 3'b010;
    else if (rot_valid[2]) rot_grant = 3'b100;
    else                   rot_grant = 3'b000;
    case (ptr_q)
      2'd1:    grant = {rot_grant[1:0], rot_grant[2]};
      2'd2:    grant = {rot_grant[0], rot_grant[2:1]};
      default: grant = rot_grant;
    endcase
  end

  always_comb begin
    sel_rd   = wb_rd[IDX_W-1:0];
    sel_data = wb_data[XLEN-1:0];
    if (grant[1]) begin
      sel_rd   = wb_rd[2*IDX_W-1:IDX_W];
      sel_data = wb_data[2*XLEN-1:XLEN];
    end
    if (grant[2]) begin
      sel_rd   = wb_rd[3*IDX_W-1:2*IDX_W];
      sel_data = wb_data[3*XLEN-1:2*XLEN];
    end
  end

  assign xfer         = |grant;
  assign wb_ready     = grant;
  assign hazard_stall = pending_q[rs1] | pending_q[rs2] | pending_q[issue_rd];
  assign issue_fire   = issue_valid && !hazard_stall && (issue_rd != '0);

  always_comb begin
    ptr_d        = ptr_q;
    pending_d    = pending_q;
    regwrite_d   = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (xfer) begin
      if (grant[0])      ptr_d = 2'd1;
      else if (grant[1]) ptr_d = 2'd2;
      else               ptr_d = 2'd0;
      pending_d[sel_rd] = 1'b0;
      if (sel_rd != '0) begin
        regwrite_d   = 1'b1;
        write_reg_d  = sel_rd;
        write_data_d = sel_data;
      end
    end
    // Issue applied after the clear so a same-index set survives.
    if (issue_fire) pending_d[issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q        <= 2'd0;
      pending_q    <= '0;
      regwrite_q   <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      ptr_q        <= ptr_d;
      pending_q    <= pending_d;
      regwrite_q   <= regwrite_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  assign RegWrite   = regwrite_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// tb/tb_regfile_wb_sched.sv - directed bench with a cycle-level reference model of the write-back scheduler
module tb_regfile_wb_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  wb_valid;
  logic [14:0] wb_rd;
  logic [95:0] wb_data;
  logic [2:0]  wb_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd, rs1, rs2;
  logic        hazard_stall;
  logic        RegWrite;
  logic [4:0]  write_reg;
  logic [31:0] write_data;

  int checks = 0;
  int failures = 0;

  regfile_wb_sched dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2),
    .hazard_stall(hazard_stall),
    .RegWrite(RegWrite), .write_reg(write_reg), .write_data(write_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pointer as an integer, pending as a plain bit set.
  int          m_ptr;
  logic [31:0] m_pend;
  logic        m_we;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;
  bit          m_known = 0;

  function automatic int pick(input logic [2:0] v, input int p);
    for (int k = 0; k < 3; k++) begin
      if (v[(p + k) % 3]) return (p + k) % 3;
    end
    return -1;
  endfunction

  always @(posedge clk) begin : model
    int g;
    logic [4:0] rd;
    bit stall;
    if (reset) begin
      m_ptr   <= 0;
      m_pend  <= '0;
      m_we    <= 1'b0;
      m_wr    <= '0;
      m_wd    <= '0;
      m_known <= 1;
    end else if (m_known) begin
      g = pick(wb_valid, m_ptr);
      stall = m_pend[rs1] | m_pend[rs2] | m_pend[issue_rd];
      m_we <= 1'b0;
      if (g >= 0) begin
        rd = wb_rd[5*g +: 5];
        m_pend[rd] <= 1'b0;
        m_ptr <= (g + 1) % 3;
        if (rd != 0) begin
          m_we <= 1'b1;
          m_wr <= rd;
          m_wd <= wb_data[32*g +: 32];
        end
      end
      if (issue_valid && !stall && issue_rd != 0) m_pend[issue_rd] <= 1'b1;
    end
  end

  always @(negedge clk) begin : compare
    int g;
    logic [2:0] eg;
    if (m_known && !reset) begin
      g = pick(wb_valid, m_ptr);
      eg = (g >= 0) ? 3'(1 << g) : 3'b000;
      chk("model_wb_ready", 32'(wb_ready), 32'(eg));
      chk("model_stall", 32'(hazard_stall), 32'(m_pend[rs1] | m_pend[rs2] | m_pend[issue_rd]));
      chk("model_regwrite", 32'(RegWrite), 32'(m_we));
      if (m_we) begin
        chk("model_write_reg", 32'(write_reg), 32'(m_wr));
        chk("model_write_data", write_data, m_wd);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_valid = '0; issue_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wb_valid = '0; wb_rd = '0; wb_data = '0;
    issue_valid = 1'b0; issue_rd = '0; rs1 = '0; rs2 = '0;
    tick();
    tick();
    #2;
    chk("reset_regwrite", 32'(RegWrite), 32'd0);
    chk("reset_write_reg", 32'(write_reg), 32'd0);
    chk("reset_write_data", write_data, 32'd0);
    chk("reset_stall", 32'(hazard_stall), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Single ALU write-back
    wb_valid = 3'b001; wb_rd = {5'd0, 5'd0, 5'd1}; wb_data = {64'd0, 32'h12345678};
    #2 chk("single_ready", 32'(wb_ready), 32'b001);
    tick(); idle();
    #2;
    chk("single_regwrite", 32'(RegWrite), 32'd1);
    chk("single_write_reg", 32'(write_reg), 32'd1);
    chk("single_write_data", write_data, 32'h12345678);
    tick();
    #2 chk("single_regwrite_drop", 32'(RegWrite), 32'd0);

    // Round-robin from a fresh reset
    do_reset();
    wb_valid = 3'b111; wb_rd = {5'd12, 5'd11, 5'd10};
    wb_data = {32'hA0000002, 32'hA0000001, 32'hA0000000};
    for (int c = 0; c < 6; c++) begin
      #2;
      chk("rr_grant", 32'(wb_ready), 32'(1 << (c % 3)));
      if (c > 0) begin
        chk("rr_regwrite", 32'(RegWrite), 32'd1);
        chk("rr_write_reg", 32'(write_reg), 32'(10 + (c - 1) % 3));
      end
      tick();
    end
    idle();
    #2;
    chk("rr_last_reg", 32'(write_reg), 32'd12);
    chk("rr_last_data", write_data, 32'hA0000002);

    // RAW on reg 5 resolved by load write-back
    issue_valid = 1'b1; issue_rd = 5'd5;
    #2 chk("raw_issue_nostall", 32'(hazard_stall), 32'd0);
    tick(); issue_valid = 1'b0; issue_rd = 5'd0; rs1 = 5'd5;
    #2 chk("raw_stall", 32'(hazard_stall), 32'd1);
    wb_valid = 3'b010; wb_rd = {5'd0, 5'd5, 5'd0}; wb_data = {32'd0, 32'hDEADBEEF, 32'd0};
    #1 chk("raw_load_grant", 32'(wb_ready), 32'b010);
    tick(); idle();
    #2;
    chk("raw_cleared", 32'(hazard_stall), 32'd0);
    chk("raw_write_reg", 32'(write_reg), 32'd5);
    chk("raw_write_data", write_data, 32'hDEADBEEF);
    rs1 = 5'd0;

    // x0 transfer and x0 issue
    wb_valid = 3'b001; wb_rd = 15'd0; wb_data = {64'd0, 32'hABCDEF01};
    issue_valid = 1'b1; issue_rd = 5'd0;
    #2 chk("x0_ready", 32'(wb_ready), 32'b001);
    tick(); idle();
    #2;
    chk("x0_no_regwrite", 32'(RegWrite), 32'd0);
    chk("x0_no_stall", 32'(hazard_stall), 32'd0);

    // Same-edge set and clear of reg 7, then WAW
    issue_valid = 1'b1; issue_rd = 5'd7;
    wb_valid = 3'b100; wb_rd = {5'd7, 5'd0, 5'd0}; wb_data = {32'h00000077, 64'd0};
    #2;
    chk("same_edge_nostall", 32'(hazard_stall), 32'd0);
    chk("same_edge_grant", 32'(wb_ready), 32'b100);
    tick(); idle(); issue_rd = 5'd0; rs2 = 5'd7;
    #2;
    chk("set_wins_stall", 32'(hazard_stall), 32'd1);
    chk("same_edge_write_reg", 32'(write_reg), 32'd7);
    rs2 = 5'd0; issue_valid = 1'b1; issue_rd = 5'd7;
    #2 chk("waw_stall", 32'(hazard_stall), 32'd1);
    tick(); issue_valid = 1'b0;
    wb_valid = 3'b001; wb_rd = {10'd0, 5'd7}; wb_data = {64'd0, 32'h0000F00D};
    tick(); idle();
    #2 chk("waw_cleared", 32'(hazard_stall), 32'd0);
    issue_rd = 5'd0;

    // Reset while requests and a pending bit are live
    issue_valid = 1'b1; issue_rd = 5'd3;
    tick(); issue_valid = 1'b0; issue_rd = 5'd0; rs1 = 5'd3;
    #2 chk("pre_reset_stall", 32'(hazard_stall), 32'd1);
    wb_valid = 3'b111; wb_rd = {5'd9, 5'd8, 5'd6};
    wb_data = {32'hC2, 32'hC1, 32'hC0};
    do_reset();
    #2;
    chk("post_reset_regwrite", 32'(RegWrite), 32'd0);
    chk("post_reset_stall", 32'(hazard_stall), 32'd0);
    chk("post_reset_grant", 32'(wb_ready), 32'b001);
    tick();
    #2 chk("post_reset_next_grant", 32'(wb_ready), 32'b010);
    idle();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
